// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: tracks destinations through dec/ex/dm/wb, forwards operands, stalls on load-use.
// Optional feature: define HFU_R0_ZERO_EN to treat register 0 as hardwired zero.
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int IMM_W  = 8,
  parameter int INS_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic              ins_valid,
  output logic              stall,
  output logic [4:0]        op_dec,
  output logic [IMM_W-1:0]  imm,
  output logic              imm_sel,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic [REG_AW-1:0] RW_dm,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic              mem_mux_sel_dm
);

  localparam int RB_LSB = 4;
  localparam int RA_LSB = RB_LSB + REG_AW;
  localparam int RW_LSB = RA_LSB + REG_AW;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  // Incoming instruction fields and decode
  logic [4:0]        op_in;
  logic [REG_AW-1:0] rw_in;
  logic [REG_AW-1:0] ra_in;
  logic [REG_AW-1:0] rb_in;
  logic [IMM_W-1:0]  imm_in;
  logic              is_jmp;
  logic              is_cj;
  logic              is_ld;
  logic              is_st;
  logic              is_imm;
  logic              reads_a;
  logic              reads_b;
  logic              writes_rw;
  logic              take;
  logic              unused_ins_bit;

  // Registered dec state
  logic [REG_AW-1:0] rw_dec;
  logic [REG_AW-1:0] ra_dec;
  logic [REG_AW-1:0] rb_dec;
  logic              wv_dec;
  logic              av_dec;
  logic              bv_dec;
  logic              ld_dec;
  logic              st_dec;

  // Downstream stage state
  logic [REG_AW-1:0] rw_ex;
  logic              wv_ex;
  logic              mem_mux_sel_ex;
  logic              wv_dm;
  logic [REG_AW-1:0] rw_wb;
  logic              wv_wb;

  assign op_in          = ins[INS_W-1 -: 5];
  assign rw_in          = ins[RW_LSB +: REG_AW];
  assign ra_in          = ins[RA_LSB +: REG_AW];
  assign rb_in          = ins[RB_LSB +: REG_AW];
  assign imm_in         = ins[IMM_W:1];
  assign unused_ins_bit = ins[0];

  always_comb begin
    is_jmp    = (op_in == 5'b11000);
    is_cj     = (op_in[4:2] == 3'b111);
    is_ld     = (op_in == 5'b10100);
    is_st     = (op_in == 5'b10101);
    is_imm    = (op_in[4:3] == 2'b01);
    reads_a   = ins_valid & ~is_jmp & ~is_cj;
    reads_b   = ins_valid & ~(is_jmp | is_cj | is_imm | is_ld);
`ifdef HFU_R0_ZERO_EN
    writes_rw = ins_valid & ~(is_jmp | is_cj | is_st) & (rw_in != '0);
`else
    writes_rw = ins_valid & ~(is_jmp | is_cj | is_st);
`endif
  end

  // A load in dec whose destination the incoming instruction reads must wait one cycle.
  assign stall = ins_valid & ld_dec & wv_dec &
                 ((reads_a & (ra_in == rw_dec)) | (reads_b & (rb_in == rw_dec)));

  assign take = ins_valid & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_dec  <= '0;
      imm     <= '0;
      imm_sel <= 1'b0;
      rw_dec  <= '0;
      ra_dec  <= '0;
      rb_dec  <= '0;
      wv_dec  <= 1'b0;
      av_dec  <= 1'b0;
      bv_dec  <= 1'b0;
      ld_dec  <= 1'b0;
      st_dec  <= 1'b0;
    end else if (take) begin
      op_dec  <= op_in;
      imm     <= imm_in;
      imm_sel <= is_imm;
      rw_dec  <= rw_in;
      ra_dec  <= ra_in;
      rb_dec  <= rb_in;
      wv_dec  <= writes_rw;
      av_dec  <= reads_a;
      bv_dec  <= reads_b;
      ld_dec  <= is_ld;
      st_dec  <= is_st;
    end else begin
      op_dec  <= '0;
      imm     <= '0;
      imm_sel <= 1'b0;
      rw_dec  <= '0;
      ra_dec  <= '0;
      rb_dec  <= '0;
      wv_dec  <= 1'b0;
      av_dec  <= 1'b0;
      bv_dec  <= 1'b0;
      ld_dec  <= 1'b0;
      st_dec  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_ex          <= '0;
      wv_ex          <= 1'b0;
      mem_en_ex      <= 1'b0;
      mem_rw_ex      <= 1'b0;
      mem_mux_sel_ex <= 1'b0;
      RW_dm          <= '0;
      wv_dm          <= 1'b0;
      mem_mux_sel_dm <= 1'b0;
      rw_wb          <= '0;
      wv_wb          <= 1'b0;
    end else begin
      rw_ex          <= rw_dec;
      wv_ex          <= wv_dec;
      mem_en_ex      <= ld_dec | st_dec;
      mem_rw_ex      <= st_dec;
      mem_mux_sel_ex <= ld_dec;
      RW_dm          <= rw_ex;
      wv_dm          <= wv_ex;
      mem_mux_sel_dm <= mem_mux_sel_ex;
      rw_wb          <= RW_dm;
      wv_wb          <= wv_dm;
    end
  end

  // Youngest matching producer wins; stages without a valid write never match.
  function automatic logic [1:0] fwd_sel(
    input logic              use_v,
    input logic [REG_AW-1:0] src,
    input logic              v_ex,
    input logic [REG_AW-1:0] r_ex,
    input logic              v_dm,
    input logic [REG_AW-1:0] r_dm,
    input logic              v_wb,
    input logic [REG_AW-1:0] r_wb
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_v && v_ex && (src == r_ex)) begin
      sel = SEL_EX;
    end else if (use_v && v_dm && (src == r_dm)) begin
      sel = SEL_DM;
    end else if (use_v && v_wb && (src == r_wb)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    mux_sel_A = fwd_sel(av_dec, ra_dec, wv_ex, rw_ex, wv_dm, RW_dm, wv_wb, rw_wb);
    mux_sel_B = fwd_sel(bv_dec, rb_dec, wv_ex, rw_ex, wv_dm, RW_dm, wv_wb, rw_wb);
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit (forwarding distances, load-use, store/jump, immediate, R0, reset).
// Build with +define+HFU_R0_ZERO_EN to check the hardwired-zero R0 variant.
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset;
  logic [23:0] ins;
  logic        ins_valid;
  logic        stall;
  logic [4:0]  op_dec;
  logic [7:0]  imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A;
  logic [1:0]  mux_sel_B;
  logic [4:0]  RW_dm;
  logic        mem_en_ex;
  logic        mem_rw_ex;
  logic        mem_mux_sel_dm;

  int errors = 0;
  int checks = 0;

  hazard_forward_unit #(.REG_AW(5), .IMM_W(8), .INS_W(24)) dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid), .stall(stall),
    .op_dec(op_dec), .imm(imm), .imm_sel(imm_sel), .mux_sel_A(mux_sel_A),
    .mux_sel_B(mux_sel_B), .RW_dm(RW_dm), .mem_en_ex(mem_en_ex),
    .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] rw,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {op, rw, ra, rb, 4'b0000};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction across a rising edge, then sample 1 time unit later.
  task automatic applyStimulus(input logic [23:0] i, input logic v);
    ins       = i;
    ins_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) applyStimulus(24'h0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stall"}, {31'b0, stall}, 32'd0);
    checkOutput({tag, ".op_dec"}, {27'b0, op_dec}, 32'd0);
    checkOutput({tag, ".imm"}, {24'b0, imm}, 32'd0);
    checkOutput({tag, ".imm_sel"}, {31'b0, imm_sel}, 32'd0);
    checkOutput({tag, ".sel_A"}, {30'b0, mux_sel_A}, 32'd0);
    checkOutput({tag, ".sel_B"}, {30'b0, mux_sel_B}, 32'd0);
    checkOutput({tag, ".RW_dm"}, {27'b0, RW_dm}, 32'd0);
    checkOutput({tag, ".mem_en"}, {31'b0, mem_en_ex}, 32'd0);
    checkOutput({tag, ".mem_rw"}, {31'b0, mem_rw_ex}, 32'd0);
    checkOutput({tag, ".mem_mux"}, {31'b0, mem_mux_sel_dm}, 32'd0);
  endtask

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_LD  = 5'b10100;
  localparam logic [4:0] OP_ST  = 5'b10101;
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_IMM = 5'b01000;

  initial begin
    logic [23:0] w;
    logic [1:0]  r0_exp;
    ins       = 24'h0;
    ins_valid = 1'b0;
    reset     = 1'b0;

    // Reset held, then released with no valid instructions
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("in_reset");
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(24'h0, 1'b0);
      checkAllZero($sformatf("post_reset%0d", c));
    end

    // Forwarding distance 1..4 for RA=3
    for (int d = 1; d <= 4; d++) begin
      flush();
      applyStimulus(mk(OP_ADD, 5'd3, 5'd10, 5'd11), 1'b1);
      for (int b = 1; b < d; b++) applyStimulus(24'h0, 1'b0);
      applyStimulus(mk(OP_ADD, 5'd8, 5'd3, 5'd12), 1'b1);
      checkOutput($sformatf("dist%0d.sel_A", d), {30'b0, mux_sel_A},
                  (d == 1) ? 32'd1 : (d == 2) ? 32'd2 : (d == 3) ? 32'd3 : 32'd0);
      checkOutput($sformatf("dist%0d.sel_B", d), {30'b0, mux_sel_B}, 32'd0);
    end

    // Load-use on RB
    flush();
    applyStimulus(mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b1);
    checkOutput("ld.op_dec", {27'b0, op_dec}, {27'b0, OP_LD});
    ins = mk(OP_ADD, 5'd6, 5'd2, 5'd5);
    ins_valid = 1'b1;
    #1;
    checkOutput("lu.stall_hi", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("lu.stall_lo", {31'b0, stall}, 32'd0);
    checkOutput("lu.bubble_op", {27'b0, op_dec}, 32'd0);
    checkOutput("lu.mem_en", {31'b0, mem_en_ex}, 32'd1);
    checkOutput("lu.mem_rw", {31'b0, mem_rw_ex}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lu.add_op", {27'b0, op_dec}, {27'b0, OP_ADD});
    checkOutput("lu.sel_B", {30'b0, mux_sel_B}, 32'd2);
    checkOutput("lu.sel_A", {30'b0, mux_sel_A}, 32'd0);
    checkOutput("lu.mem_mux_dm", {31'b0, mem_mux_sel_dm}, 32'd1);
    checkOutput("lu.RW_dm", {27'b0, RW_dm}, 32'd5);
    checkOutput("lu.no_restall", {31'b0, stall}, 32'd0);

    // Back-to-back dependent loads stall once
    flush();
    applyStimulus(mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b1);
    ins = mk(OP_LD, 5'd7, 5'd5, 5'd0);
    #1;
    checkOutput("ldld.stall_hi", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ldld.stall_lo", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ldld.sel_A", {30'b0, mux_sel_A}, 32'd2);
    checkOutput("ldld.once", {31'b0, stall}, 32'd0);

    // Store does not write its RW field
    flush();
    applyStimulus(mk(OP_ST, 5'd7, 5'd1, 5'd2), 1'b1);
    applyStimulus(mk(OP_ADD, 5'd8, 5'd7, 5'd4), 1'b1);
    checkOutput("st.sel_A", {30'b0, mux_sel_A}, 32'd0);
    checkOutput("st.mem_rw", {31'b0, mem_rw_ex}, 32'd1);
    checkOutput("st.mem_en", {31'b0, mem_en_ex}, 32'd1);

    // Jump with all field bits set writes nothing
    flush();
    applyStimulus({OP_JMP, 19'h7FFFF}, 1'b1);
    checkOutput("jmp.op_dec", {27'b0, op_dec}, {27'b0, OP_JMP});
    applyStimulus(mk(OP_ADD, 5'd8, 5'd31, 5'd30), 1'b1);
    checkOutput("jmp.sel_A", {30'b0, mux_sel_A}, 32'd0);
    checkOutput("jmp.sel_B", {30'b0, mux_sel_B}, 32'd0);

    // Immediate: RB field (=20) is ignored for stall and forwarding
    flush();
    applyStimulus(mk(OP_LD, 5'd20, 5'd1, 5'd0), 1'b1);
    w = {OP_IMM, 5'd9, 5'd1, 9'b0};
    w[8:1] = 8'hA5;
    ins = w;
    #1;
    checkOutput("imm.stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("imm.imm_sel", {31'b0, imm_sel}, 32'd1);
    checkOutput("imm.imm", {24'b0, imm}, 32'hA5);
    checkOutput("imm.op_dec", {27'b0, op_dec}, {27'b0, OP_IMM});
    checkOutput("imm.sel_B", {30'b0, mux_sel_B}, 32'd0);
    checkOutput("imm.sel_A", {30'b0, mux_sel_A}, 32'd0);

    // Register 0 as a destination
`ifdef HFU_R0_ZERO_EN
    r0_exp = 2'b00;
`else
    r0_exp = 2'b01;
`endif
    flush();
    applyStimulus(mk(OP_ADD, 5'd0, 5'd1, 5'd2), 1'b1);
    applyStimulus(mk(OP_ADD, 5'd8, 5'd0, 5'd3), 1'b1);
    checkOutput("r0.sel_A", {30'b0, mux_sel_A}, {30'b0, r0_exp});
    checkOutput("r0.sel_B", {30'b0, mux_sel_B}, 32'd0);

    // Reset mid-stream discards a pending load-use hazard
    flush();
    applyStimulus(mk(OP_LD, 5'd9, 5'd1, 5'd0), 1'b1);
    ins = mk(OP_ADD, 5'd10, 5'd9, 5'd2);
    #1;
    checkOutput("mid.stall_pre", {31'b0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    checkAllZero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(mk(OP_ADD, 5'd10, 5'd9, 5'd2), 1'b1);
    checkOutput("mid.op_after", {27'b0, op_dec}, {27'b0, OP_ADD});
    checkOutput("mid.sel_A_after", {30'b0, mux_sel_A}, 32'd0);
    checkOutput("mid.sel_B_after", {30'b0, mux_sel_B}, 32'd0);
    checkOutput("mid.mem_en_after", {31'b0, mem_en_ex}, 32'd0);

    ins_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
